// File: rtl/pc_next_unit.sv
// Program counter with next-PC selection: sequential, jump, branch and JR redirects, plus a
// one-entry holding register so a redirect arriving during a stall is applied after it.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump,
  input  logic [27:0] jtarget28,
  input  logic        branch,
  input  logic [31:0] boffset,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pending,
  output logic        misalign
);

  typedef enum logic [0:0] {StIdle, StHeld} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        misalign_q, misalign_d;

  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        unused_boffset_hi;

  // The branch offset is shifted by two, so its top bits fall off the 32-bit sum.
  assign unused_boffset_hi = ^boffset[31:30];

  assign pc_plus4       = pc_q + 32'd4;
  assign redirect_valid = jr | jump | branch;

  always_comb begin
    if (jr) begin
      redirect_target = {jr_addr[31:2], 2'b00};
    end else if (jump) begin
      redirect_target = {pc_plus4[31:28], jtarget28};
    end else begin
      redirect_target = pc_plus4 + {boffset[29:0], 2'b00};
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_pc_d  = hold_pc_q;
    misalign_d = misalign_q;
    unique case (state_q)
      StIdle: begin
        if (!stall) begin
          pc_d = redirect_valid ? redirect_target : pc_plus4;
        end else if (redirect_valid) begin
          hold_pc_d = redirect_target;
          state_d   = StHeld;
        end
        // JR is selected in this state whether taken directly or captured.
        if (jr && (jr_addr[1:0] != 2'b00)) begin
          misalign_d = 1'b1;
        end
      end
      StHeld: begin
        // Oldest redirect wins; anything presented while held is dropped.
        if (!stall) begin
          pc_d    = hold_pc_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      hold_pc_q  <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_pc_q  <= hold_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign pending  = (state_q == StHeld);
  assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: a vector table for single-cycle redirects plus hand-written
// sequences for stall buffering, misalign stickiness and reset during a held redirect.
module tb_pc_next_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic [27:0] jtarget28;
  logic        branch;
  logic [31:0] boffset;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pending;
  logic        misalign;

  int tests_run;
  int tests_failed;

  pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .jump      (jump),
    .jtarget28 (jtarget28),
    .branch    (branch),
    .boffset   (boffset),
    .jr        (jr),
    .jr_addr   (jr_addr),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .pending   (pending),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc_start;
    logic        jump;
    logic [27:0] jt;
    logic        branch;
    logic [31:0] boff;
    logic        jr;
    logic [31:0] jra;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    stall = 1'b0; jump = 1'b0; jtarget28 = '0; branch = 1'b0; boffset = '0;
    jr = 1'b0; jr_addr = '0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    clear_req();
    jr = 1'b1; jr_addr = v;
    tick();
    clear_req();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    clear_req();
    rst_n = 1'b0;

    vecs[0] = '{32'h3000_0010, 1'b1, 28'h0ABC_DE4, 1'b0, 32'h0, 1'b0, 32'h0, 32'h30AB_CDE4};
    vecs[1] = '{32'hFFFF_FFFC, 1'b0, 28'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0000};
    vecs[2] = '{32'h0000_0100, 1'b0, 28'h0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0000_00FC};
    vecs[3] = '{32'h0000_0100, 1'b0, 28'h0, 1'b1, 32'h0000_0003, 1'b0, 32'h0, 32'h0000_0110};
    vecs[4] = '{32'h4FFF_FFFC, 1'b1, 28'h000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 32'h5000_0010};
    vecs[5] = '{32'h0000_0200, 1'b1, 28'h000_0400, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0000_0400};
    vecs[6] = '{32'h0000_0010, 1'b1, 28'h000_0400, 1'b0, 32'h0, 1'b1, 32'h1234_5678,
                32'h1234_5678};
    vecs[7] = '{32'hFFFF_FFF0, 1'b0, 28'h0, 1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0000_0014};

    // Reset values, visible without a clock edge
    #2;
    check("reset_pc", pc, 32'h0);
    check("reset_pc_plus4", pc_plus4, 32'h4);
    check("reset_pending", {31'h0, pending}, 32'h0);
    check("reset_misalign", {31'h0, misalign}, 32'h0);
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("run_pc0", pc, 32'h0);
    tick(); check("run_pc4", pc, 32'h4);
    tick(); check("run_pc8", pc, 32'h8);
    tick(); check("run_pc12", pc, 32'hC);
    check("run_pending", {31'h0, pending}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      set_pc(vecs[i].pc_start);
      check($sformatf("vec%0d_start", i), pc, vecs[i].pc_start);
      check($sformatf("vec%0d_plus4", i), pc_plus4, vecs[i].pc_start + 32'd4);
      jump = vecs[i].jump; jtarget28 = vecs[i].jt;
      branch = vecs[i].branch; boffset = vecs[i].boff;
      jr = vecs[i].jr; jr_addr = vecs[i].jra;
      tick();
      clear_req();
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_pending", i), {31'h0, pending}, 32'h0);
      check($sformatf("vec%0d_misalign", i), {31'h0, misalign}, 32'h0);
    end

    // Priority jr > jump > branch, with a misaligned JR target
    set_pc(32'h40);
    jr = 1'b1; jr_addr = 32'h0000_2002;
    jump = 1'b1; jtarget28 = 28'h000_0800;
    branch = 1'b1; boffset = 32'h10;
    tick();
    clear_req();
    check("prio_pc", pc, 32'h2000);
    check("prio_misalign", {31'h0, misalign}, 32'h1);
    tick(); tick();
    check("misalign_sticky", {31'h0, misalign}, 32'h1);
    check("misalign_run_pc", pc, 32'h2008);
    #2 rst_n = 1'b0;
    #1;
    check("misalign_cleared", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Stall buffering: oldest redirect wins, redirect on release cycle dropped
    set_pc(32'h80);
    stall = 1'b1; branch = 1'b1; boffset = 32'h4;
    tick();
    check("stall1_pc", pc, 32'h80);
    check("stall1_pending", {31'h0, pending}, 32'h1);
    branch = 1'b0; jump = 1'b1; jtarget28 = 28'h000_0100;
    tick();
    check("stall2_pc", pc, 32'h80);
    check("stall2_pending", {31'h0, pending}, 32'h1);
    jump = 1'b0;
    tick();
    check("stall3_pc", pc, 32'h80);
    stall = 1'b0; jump = 1'b1; jtarget28 = 28'h000_0200;
    tick();
    clear_req();
    check("release_pc", pc, 32'h94);
    check("release_pending", {31'h0, pending}, 32'h0);
    tick();
    check("after_release_pc", pc, 32'h98);

    // Misaligned JR captured during a stall
    stall = 1'b1; jr = 1'b1; jr_addr = 32'h0000_3003;
    tick();
    clear_req();
    stall = 1'b1;
    check("cap_misalign", {31'h0, misalign}, 32'h1);
    check("cap_pc_hold", pc, 32'h98);
    stall = 1'b0;
    tick();
    check("cap_release_pc", pc, 32'h3000);

    // Reset while a redirect is held
    stall = 1'b1; branch = 1'b1; boffset = 32'h100;
    tick();
    clear_req();
    stall = 1'b1;
    check("held_pending", {31'h0, pending}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_held_pc", pc, 32'h0);
    check("rst_held_pending", {31'h0, pending}, 32'h0);
    check("rst_held_misalign", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    tick();
    check("post_rst_pc", pc, 32'h4);
    check("post_rst_pending", {31'h0, pending}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter register and next-PC selector for the MIPS datapath. It consumes the 28-bit word-aligned jump field (26-bit instruction index shifted left by 2) and forms the 32-bit jump address {PC+4[31:28], target28}. It also resolves branch and jump-register redirects, and holds the PC while the pipeline is stalled. A redirect that arrives during a stall is buffered in a one-entry holding register so it is not lost.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  1 = hold PC this cycle.
- jump  input  1  J/JAL redirect request.
- jtarget28  input  28  shifted jump field; bits [1:0] always 0.
- branch  input  1  taken-branch redirect request.
- boffset  input  32  sign-extended 16-bit branch immediate, in words; not yet shifted.
- jr  input  1  JR/JALR redirect request.
- jr_addr  input  32  register-sourced jump target.
- pc  output  32  current PC (registered).
- pc_plus4  output  32  pc + 4 (combinational from pc).
- pending  output  1  holding register occupied (registered).
- misalign  output  1  sticky: a JR target with nonzero [1:0] was taken (registered).

## Operation
- **Target arithmetic**: all arithmetic is modulo 2^32 and wraps silently.
  - Jump target: {pc_plus4[31:28], jtarget28}.
  - Branch target: pc_plus4 + {boffset[29:0], 2'b00}.
  - JR target: {jr_addr[31:2], 2'b00}.
- **Same-cycle priority**: jr > jump > branch. Lower-priority requests in the same cycle are discarded.
- **Redirect valid**: a cycle's redirect is valid when any of jr/jump/branch is 1. Its target is computed from that cycle's pc.
- **State**: IDLE (pending=0) and HELD (pending=1, hold_pc valid).
- **IDLE, stall=0**: pc <= redirect target if a redirect is valid, else pc_plus4.
- **IDLE, stall=1**: pc holds. If a redirect is valid, capture its target into hold_pc and go to HELD.
- **HELD, stall=1**: pc holds. New redirects are ignored; the oldest redirect wins.
- **HELD, stall=0**: pc <= hold_pc and go to IDLE. A redirect presented in this same cycle is discarded.
- **misalign**:
  - Set in the cycle a JR target is selected, either directly or by capture, when jr_addr[1:0] != 0.
  - Cleared only by reset.
  - The low bits of the target are still forced to 00.

## Timing
- **Reset** (asynchronous assertion, synchronous-edge release): pc=RESET_PC, pending=0, hold_pc=0, misalign=0. pc_plus4 = RESET_PC+4 immediately.
- **Latency**: a redirect with stall=0 appears on pc after the next rising edge, i.e. one cycle.
- **Stalled redirect**: a redirect captured during a stall appears on pc one edge after the first cycle with stall=0.
- **Sequential flow**: with no stall and no redirect, pc advances by 4 every cycle.
- **Reset mid-HELD**: the buffered redirect is lost, pending=0, and pc=RESET_PC.
- **Inputs**: must be stable before the rising edge. There are no combinational paths from inputs to pc, pending or misalign.

## Test plan
- **Reset and run**: release rst_n with all requests at 0 -> pc = 0, 4, 8, 12 on successive edges; pending=0; misalign=0.
- **Jump and wrap**:
  - pc=32'h3000_0010, jump=1, jtarget28=28'h0ABC_DE4 -> next pc = 32'h30AB_CDE4.
  - pc=32'hFFFF_FFFC with no redirect -> next pc = 0.
- **Branch arithmetic**:
  - pc=32'h0000_0100, branch=1, boffset=32'hFFFF_FFFE -> next pc = 32'h0000_00FC.
  - boffset=3 -> next pc = 32'h0000_0110.
- **Priority and misalign**:
  - pc=0x40 with jr=1, jr_addr=32'h0000_2002, jump=1 and branch=1 in the same cycle -> next pc = 32'h0000_2000; misalign=1 and stays 1.
  - misalign clears only on rst_n=0.
- **Stall buffering**:
  - pc=0x80, stall=1 for 3 cycles with branch=1 (boffset=4) in cycle 1 and jump=1 in cycle 2 -> pc holds at 0x80; pending=1 from cycle 2.
  - First cycle with stall=0 -> pc=0x94, pending=0; the jump is ignored.
- **Reset during HELD**: capture a redirect with stall=1, then pulse rst_n low mid-cycle -> pc=RESET_PC and pending=0 immediately, without waiting for a clock edge; no stale redirect is applied after release.
